// File: rtl/tomasulo_pkg.sv
`default_nettype none
// ============================================================================
// tomasulo_pkg : shared opcodes, station state encoding and default widths
// Revision 1.0
// ============================================================================
package tomasulo_pkg;

  localparam int DEF_DATA_W = 32;
  localparam int DEF_TAG_W  = 6;
  localparam int DEF_OPC_W  = 6;

  localparam logic [5:0] OP_ADD = 6'd0;
  localparam logic [5:0] OP_SUB = 6'd1;

  localparam int TAG_NONE = 0;

  typedef enum logic [2:0] {
    ST_FREE  = 3'd0,
    ST_WAIT  = 3'd1,
    ST_READY = 3'd2,
    ST_EXEC  = 3'd3,
    ST_DONE  = 3'd4
  } rs_state_t;

endpackage
`default_nettype wire

// File: rtl/rs_entry.sv
`default_nettype none
// ============================================================================
// rs_entry : one reservation station (state, operands, snoop/bypass capture)
// Revision 1.0
// ============================================================================
module rs_entry
  import tomasulo_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int TAG_W  = DEF_TAG_W
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              alloc,
  input  logic              alloc_sub,
  input  logic [DATA_W-1:0] a_in,
  input  logic              a_invalid,
  input  logic [DATA_W-1:0] b_in,
  input  logic              b_invalid,
  input  logic [DATA_W-1:0] cdb_data_in,
  input  logic [TAG_W-1:0]  cdb_source_in,
  input  logic              cdb_write_in,
  input  logic              dispatch,
  input  logic              complete,
  input  logic [DATA_W-1:0] result_in,
  input  logic              rel,
  output rs_state_t         state,
  output logic              op_sub,
  output logic [DATA_W-1:0] a_val,
  output logic [DATA_W-1:0] b_val,
  output logic [DATA_W-1:0] result
);

  rs_state_t         state_q, state_d;
  logic              sub_q, sub_d;
  logic [DATA_W-1:0] a_val_q, a_val_d, b_val_q, b_val_d;
  logic [TAG_W-1:0]  a_tag_q, a_tag_d, b_tag_q, b_tag_d;
  logic              a_pend_q, a_pend_d, b_pend_q, b_pend_d;
  logic [DATA_W-1:0] result_q, result_d;
  logic              a_hit, b_hit, a_byp, b_byp;

  assign a_hit = a_pend_q && cdb_write_in && (a_tag_q == cdb_source_in);
  assign b_hit = b_pend_q && cdb_write_in && (b_tag_q == cdb_source_in);
  // Producer broadcasting in the issue cycle: take its value instead of waiting.
  assign a_byp = a_invalid && cdb_write_in && (a_in[TAG_W-1:0] == cdb_source_in);
  assign b_byp = b_invalid && cdb_write_in && (b_in[TAG_W-1:0] == cdb_source_in);

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= ST_FREE;
      sub_q    <= 1'b0;
      a_val_q  <= '0;
      b_val_q  <= '0;
      a_tag_q  <= '0;
      b_tag_q  <= '0;
      a_pend_q <= 1'b0;
      b_pend_q <= 1'b0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      sub_q    <= sub_d;
      a_val_q  <= a_val_d;
      b_val_q  <= b_val_d;
      a_tag_q  <= a_tag_d;
      b_tag_q  <= b_tag_d;
      a_pend_q <= a_pend_d;
      b_pend_q <= b_pend_d;
      result_q <= result_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    sub_d    = sub_q;
    a_val_d  = a_val_q;
    b_val_d  = b_val_q;
    a_tag_d  = a_tag_q;
    b_tag_d  = b_tag_q;
    a_pend_d = a_pend_q;
    b_pend_d = b_pend_q;
    result_d = result_q;
    case (state_q)
      ST_FREE: begin
        if (alloc) begin
          sub_d    = alloc_sub;
          a_tag_d  = a_in[TAG_W-1:0];
          b_tag_d  = b_in[TAG_W-1:0];
          a_val_d  = a_byp ? cdb_data_in : a_in;
          b_val_d  = b_byp ? cdb_data_in : b_in;
          a_pend_d = a_invalid && !a_byp;
          b_pend_d = b_invalid && !b_byp;
          state_d  = (a_pend_d || b_pend_d) ? ST_WAIT : ST_READY;
        end
      end
      ST_WAIT: begin
        if (a_hit) begin
          a_val_d  = cdb_data_in;
          a_pend_d = 1'b0;
        end
        if (b_hit) begin
          b_val_d  = cdb_data_in;
          b_pend_d = 1'b0;
        end
        if (!a_pend_d && !b_pend_d) state_d = ST_READY;
      end
      ST_READY: if (dispatch) state_d = ST_EXEC;
      ST_EXEC: begin
        if (complete) begin
          result_d = result_in;
          state_d  = ST_DONE;
        end
      end
      ST_DONE: if (rel) state_d = ST_FREE;
      default: state_d = ST_FREE;
    endcase
  end

  assign state  = state_q;
  assign op_sub = sub_q;
  assign a_val  = a_val_q;
  assign b_val  = b_val_q;
  assign result = result_q;

endmodule
`default_nettype wire

// File: rtl/rs_adder_bank.sv
`default_nettype none
// ============================================================================
// rs_adder_bank : Tomasulo adder RS bank; ADDER_SAT_EN selects saturating ALU
// Revision 1.0
// ============================================================================
module rs_adder_bank
  import tomasulo_pkg::*;
#(
  parameter int NUM_RS   = 4,
  parameter int DATA_W   = DEF_DATA_W,
  parameter int TAG_W    = DEF_TAG_W,
  parameter int RS_BASE  = 1,
  parameter int OPC_W    = DEF_OPC_W,
  parameter int EXEC_LAT = 2
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              issue,
  input  logic [OPC_W-1:0]  opcode,
  input  logic [DATA_W-1:0] A,
  input  logic [DATA_W-1:0] B,
  input  logic              A_invalid,
  input  logic              B_invalid,
  input  logic [DATA_W-1:0] CDB_data_in,
  input  logic [TAG_W-1:0]  CDB_source_in,
  input  logic              CDB_write_in,
  input  logic              CDB_xmit,
  output logic              CDB_rts,
  output logic [DATA_W-1:0] CDB_data,
  output logic [TAG_W-1:0]  CDB_source,
  output logic              CDB_write,
  output logic              available,
  output logic [TAG_W-1:0]  RS_available,
  output logic [TAG_W-1:0]  issued,
  output logic [TAG_W-1:0]  RS_executing,
  output logic              error
);

  localparam int IDX_W = (NUM_RS > 1) ? $clog2(NUM_RS) : 1;
  localparam int CNT_W = (EXEC_LAT > 1) ? $clog2(EXEC_LAT) : 1;

  rs_state_t         st      [NUM_RS];
  logic [DATA_W-1:0] a_val   [NUM_RS];
  logic [DATA_W-1:0] b_val   [NUM_RS];
  logic [DATA_W-1:0] res     [NUM_RS];
  logic [TAG_W-1:0]  tag_lut [NUM_RS];
  logic [NUM_RS-1:0] op_sub_v, is_free, is_ready, is_done;
  logic [NUM_RS-1:0] alloc_v, dispatch_v, complete_v, release_v;

  logic [IDX_W-1:0]  alloc_idx, disp_idx, done_idx;
  logic              legal, accept, start, finish, rts;
  logic [DATA_W-1:0] op_a, op_b, alu_out;
  logic              op_is_sub;

  logic              busy_q, busy_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [DATA_W-1:0] alu_res_q, alu_res_d;
  logic [TAG_W-1:0]  issued_q, issued_d;
  logic              error_q, error_d;

  // Lowest set index wins; returns 0 for an empty vector (callers gate on |v).
  function automatic logic [IDX_W-1:0] lowest(input logic [NUM_RS-1:0] v);
    logic [IDX_W-1:0] r;
    r = '0;
    for (int i = NUM_RS - 1; i >= 0; i--) begin
      if (v[i]) r = IDX_W'(i);
    end
    return r;
  endfunction

  for (genvar i = 0; i < NUM_RS; i++) begin : g_rs
    assign tag_lut[i]  = TAG_W'(RS_BASE + i);
    assign is_free[i]  = (st[i] == ST_FREE);
    assign is_ready[i] = (st[i] == ST_READY);
    assign is_done[i]  = (st[i] == ST_DONE);

    rs_entry #(
      .DATA_W (DATA_W),
      .TAG_W  (TAG_W)
    ) u_entry (
      .clock         (clock),
      .reset         (reset),
      .alloc         (alloc_v[i]),
      .alloc_sub     (opcode == OPC_W'(OP_SUB)),
      .a_in          (A),
      .a_invalid     (A_invalid),
      .b_in          (B),
      .b_invalid     (B_invalid),
      .cdb_data_in   (CDB_data_in),
      .cdb_source_in (CDB_source_in),
      .cdb_write_in  (CDB_write_in),
      .dispatch      (dispatch_v[i]),
      .complete      (complete_v[i]),
      .result_in     (alu_res_q),
      .rel           (release_v[i]),
      .state         (st[i]),
      .op_sub        (op_sub_v[i]),
      .a_val         (a_val[i]),
      .b_val         (b_val[i]),
      .result        (res[i])
    );
  end

  assign alloc_idx = lowest(is_free);
  assign disp_idx  = lowest(is_ready);
  assign done_idx  = lowest(is_done);

  assign legal  = (opcode == OPC_W'(OP_ADD)) || (opcode == OPC_W'(OP_SUB));
  assign accept = issue && available && legal;
  assign start  = !busy_q && (|is_ready);
  assign finish = busy_q && (cnt_q == '0);

  always_comb begin
    alloc_v    = '0;
    dispatch_v = '0;
    complete_v = '0;
    release_v  = '0;
    for (int i = 0; i < NUM_RS; i++) begin
      alloc_v[i]    = accept && (alloc_idx == IDX_W'(i));
      dispatch_v[i] = start && (disp_idx == IDX_W'(i));
      complete_v[i] = finish && (idx_q == IDX_W'(i));
      release_v[i]  = CDB_write && (done_idx == IDX_W'(i));
    end
  end

  assign op_a      = a_val[disp_idx];
  assign op_b      = b_val[disp_idx];
  assign op_is_sub = op_sub_v[disp_idx];

`ifdef ADDER_SAT_EN
  logic [DATA_W:0] wide;
  always_comb begin
    wide = op_is_sub ? ({op_a[DATA_W-1], op_a} - {op_b[DATA_W-1], op_b})
                     : ({op_a[DATA_W-1], op_a} + {op_b[DATA_W-1], op_b});
    // Extra sign bit disagreeing with the result MSB means signed overflow.
    if (wide[DATA_W] != wide[DATA_W-1])
      alu_out = wide[DATA_W] ? {1'b1, {(DATA_W-1){1'b0}}} : {1'b0, {(DATA_W-1){1'b1}}};
    else
      alu_out = wide[DATA_W-1:0];
  end
`else
  assign alu_out = op_is_sub ? (op_a - op_b) : (op_a + op_b);
`endif

  // Result is computed at dispatch and held while the latency counter runs.
  always_comb begin
    busy_d    = busy_q;
    idx_d     = idx_q;
    cnt_d     = cnt_q;
    alu_res_d = alu_res_q;
    if (start) begin
      busy_d    = 1'b1;
      idx_d     = disp_idx;
      cnt_d     = CNT_W'(EXEC_LAT - 1);
      alu_res_d = alu_out;
    end else if (finish) begin
      busy_d = 1'b0;
    end else if (busy_q) begin
      cnt_d = cnt_q - CNT_W'(1);
    end
  end

  always_comb begin
    issued_d = issued_q;
    if (accept) issued_d = tag_lut[alloc_idx];
    error_d = issue && !accept;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      busy_q    <= 1'b0;
      idx_q     <= '0;
      cnt_q     <= '0;
      alu_res_q <= '0;
      issued_q  <= '0;
      error_q   <= 1'b0;
    end else begin
      busy_q    <= busy_d;
      idx_q     <= idx_d;
      cnt_q     <= cnt_d;
      alu_res_q <= alu_res_d;
      issued_q  <= issued_d;
      error_q   <= error_d;
    end
  end

  // Reset masks the CDB so a DONE station cannot broadcast in the reset cycle.
  assign rts          = (|is_done) && !reset;
  assign CDB_rts      = rts;
  assign CDB_write    = rts && CDB_xmit;
  assign CDB_data     = rts ? res[done_idx] : '0;
  assign CDB_source   = rts ? tag_lut[done_idx] : TAG_W'(TAG_NONE);
  assign available    = |is_free;
  assign RS_available = available ? tag_lut[alloc_idx] : TAG_W'(TAG_NONE);
  assign issued       = issued_q;
  assign RS_executing = busy_q ? tag_lut[idx_q] : TAG_W'(TAG_NONE);
  assign error        = error_q;

endmodule
`default_nettype wire

// File: tb/tb_rs_adder_bank.sv
`default_nettype none
// ============================================================================
// tb_rs_adder_bank : scoreboard bench for rs_adder_bank (honours ADDER_SAT_EN)
// Revision 1.0
// ============================================================================
module tb_rs_adder_bank;

  localparam int DW = 32, TW = 6, OW = 6, NRS = 4, LAT = 2, BASE = 1;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic          reset, issue, A_invalid, B_invalid, CDB_xmit;
  logic [OW-1:0] opcode;
  logic [DW-1:0] A, B;
  logic [DW-1:0] ext_data;
  logic [TW-1:0] ext_src;
  logic          ext_wr, loop_en;
  logic [DW-1:0] CDB_data_in, CDB_data;
  logic [TW-1:0] CDB_source_in, CDB_source, RS_available, issued, RS_executing;
  logic          CDB_write_in, CDB_rts, CDB_write, available, error;

  // Loopback lets the bank hear its own broadcast as the shared CDB.
  assign CDB_data_in   = loop_en ? CDB_data   : ext_data;
  assign CDB_source_in = loop_en ? CDB_source : ext_src;
  assign CDB_write_in  = loop_en ? CDB_write  : ext_wr;

  rs_adder_bank #(
    .NUM_RS(NRS), .DATA_W(DW), .TAG_W(TW), .RS_BASE(BASE), .OPC_W(OW), .EXEC_LAT(LAT)
  ) dut (
    .clock(clock), .reset(reset), .issue(issue), .opcode(opcode), .A(A), .B(B),
    .A_invalid(A_invalid), .B_invalid(B_invalid),
    .CDB_data_in(CDB_data_in), .CDB_source_in(CDB_source_in), .CDB_write_in(CDB_write_in),
    .CDB_xmit(CDB_xmit), .CDB_rts(CDB_rts), .CDB_data(CDB_data), .CDB_source(CDB_source),
    .CDB_write(CDB_write), .available(available), .RS_available(RS_available),
    .issued(issued), .RS_executing(RS_executing), .error(error)
  );

  typedef struct {
    logic [DW-1:0] data;
    logic [TW-1:0] src;
  } exp_t;

  exp_t q[$];
  exp_t e;
  int   total = 0;
  int   bad = 0;

  // Signed reference arithmetic on wide integers, then wrap or clamp.
  function automatic logic [DW-1:0] ref_alu(input bit sub, input logic [DW-1:0] a, input logic [DW-1:0] b);
    longint s;
    s = sub ? (longint'($signed(a)) - longint'($signed(b))) : (longint'($signed(a)) + longint'($signed(b)));
`ifdef ADDER_SAT_EN
    if (s > 64'sd2147483647) s = 64'sd2147483647;
    if (s < -64'sd2147483648) s = -64'sd2147483648;
`endif
    return s[DW-1:0];
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h required %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic set_issue(input logic [OW-1:0] opc, input logic [DW-1:0] a, input logic ai,
                           input logic [DW-1:0] b, input logic bi);
    issue = 1'b1; opcode = opc; A = a; A_invalid = ai; B = b; B_invalid = bi;
  endtask

  task automatic drain(input string nm);
    int n;
    n = 0;
    while (q.size() != 0 && n < 100) begin
      tick();
      n++;
    end
    if (q.size() != 0) begin
      total++;
      bad++;
      $display("FAIL %s_timeout: got %0d pending results required 0", nm, q.size());
      q.delete();
    end
    repeat (3) tick();
  endtask

  // Issue inputs already set; measures cycles to the first CDB_write.
  task automatic run_lat(input string nm, input int exp_tag);
    int lat;
    lat = 0;
    for (int n = 1; n <= LAT + 6; n++) begin
      tick();
      issue = 1'b0;
      ext_wr = 1'b0;
      if (n == 1) chk({nm, "_issued"}, issued, exp_tag);
      if (CDB_write === 1'b1 && lat == 0) lat = n;
    end
    chk({nm, "_latency"}, lat, LAT + 2);
  endtask

  always @(negedge clock) begin
    if (CDB_write !== 1'b0) begin
      total++;
      if (q.size() == 0) begin
        bad++;
        $display("FAIL cdb_unexpected: got write src=%0d data=%0h required no write", CDB_source, CDB_data);
      end else begin
        e = q.pop_front();
        if (CDB_data !== e.data || CDB_source !== e.src) begin
          bad++;
          $display("FAIL cdb_result: got src=%0d data=%0h required src=%0d data=%0h",
                   CDB_source, CDB_data, e.src, e.data);
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got no finish required finish");
    $fatal(1);
  end

  initial begin
    logic [DW-1:0] bv [NRS];
    logic [DW-1:0] dv [NRS];
    logic [DW-1:0] ra, rb;
    bit            rs;
    int            k;

    reset = 1'b1; issue = 1'b0; opcode = '0; A = '0; B = '0; A_invalid = 1'b0; B_invalid = 1'b0;
    ext_data = '0; ext_src = '0; ext_wr = 1'b0; loop_en = 1'b0; CDB_xmit = 1'b1;
    repeat (3) tick();
    reset = 1'b0;
    @(negedge clock);
    chk("rst_rts", CDB_rts, 0);
    chk("rst_write", CDB_write, 0);
    chk("rst_data", CDB_data, 0);
    chk("rst_source", CDB_source, 0);
    chk("rst_error", error, 0);
    chk("rst_issued", issued, 0);
    chk("rst_exec", RS_executing, 0);
    chk("rst_avail", available, 1);
    chk("rst_rs_avail", RS_available, BASE);

    // ADD 5+7, both valid
    tick();
    set_issue(6'd0, 32'd5, 1'b0, 32'd7, 1'b0);
    q.push_back('{32'd12, TW'(BASE)});
    run_lat("add", BASE);
    drain("add");

    // SUB 3 - (tag 9), operand supplied later by the CDB
    tick();
    set_issue(6'd1, 32'd3, 1'b0, 32'd9, 1'b1);
    q.push_back('{ref_alu(1'b1, 32'd3, 32'd10), TW'(BASE)});
    tick();
    issue = 1'b0;
    repeat (4) tick();
    @(negedge clock);
    chk("wait_exec_idle", RS_executing, 0);
    chk("wait_rts", CDB_rts, 0);
    chk("wait_rs_avail", RS_available, BASE + 1);
    tick();
    ext_wr = 1'b1; ext_src = 6'd9; ext_data = 32'd10;
    tick();
    ext_wr = 1'b0;
    drain("sub_wait");

    // Same-cycle bypass of B tag 9
    tick();
    set_issue(6'd0, 32'd20, 1'b0, 32'd9, 1'b1);
    ext_wr = 1'b1; ext_src = 6'd9; ext_data = 32'd4;
    q.push_back('{32'd24, TW'(BASE)});
    run_lat("bypass", BASE);
    drain("bypass");

    // Fill all stations with waiting work, then one issue too many
    for (int j = 0; j < NRS; j++) begin
      tick();
      bv[j] = $urandom;
      set_issue(6'd0, DW'(20 + j), 1'b1, bv[j], 1'b0);
      @(negedge clock);
      chk("fill_rs_avail", RS_available, BASE + j);
    end
    tick();
    issue = 1'b0;
    @(negedge clock);
    chk("full_avail", available, 0);
    chk("full_rs_avail", RS_available, 0);
    tick();
    set_issue(6'd0, 32'd1, 1'b0, 32'd1, 1'b0);
    tick();
    issue = 1'b0;
    @(negedge clock);
    chk("full_error", error, 1);
    tick();
    @(negedge clock);
    chk("full_error_clear", error, 0);
    chk("full_still_full", available, 0);
    for (int j = 0; j < NRS; j++) begin
      tick();
      dv[j] = $urandom;
      ext_wr = 1'b1; ext_src = TW'(20 + j); ext_data = dv[j];
      q.push_back('{ref_alu(1'b0, dv[j], bv[j]), TW'(BASE + j)});
    end
    tick();
    ext_wr = 1'b0;
    drain("fill");

    // Illegal opcode
    tick();
    set_issue(6'd5, 32'd1, 1'b0, 32'd2, 1'b0);
    tick();
    issue = 1'b0;
    @(negedge clock);
    chk("illegal_error", error, 1);
    chk("illegal_avail", available, 1);
    chk("illegal_rs_avail", RS_available, BASE);
    repeat (LAT + 3) tick();
    @(negedge clock);
    chk("illegal_no_rts", CDB_rts, 0);

    // Overflow boundaries
    tick();
    set_issue(6'd0, 32'h7FFF_FFFF, 1'b0, 32'd1, 1'b0);
    q.push_back('{ref_alu(1'b0, 32'h7FFF_FFFF, 32'd1), TW'(BASE)});
    tick();
    set_issue(6'd1, 32'h8000_0000, 1'b0, 32'd1, 1'b0);
    q.push_back('{ref_alu(1'b1, 32'h8000_0000, 32'd1), TW'(BASE + 1)});
    tick();
    issue = 1'b0;
    drain("overflow");

    // Consumer waiting on this bank's own broadcast
    loop_en = 1'b1;
    tick();
    set_issue(6'd0, 32'd100, 1'b0, 32'd23, 1'b0);
    q.push_back('{32'd123, TW'(BASE)});
    tick();
    set_issue(6'd1, 32'd500, 1'b0, DW'(BASE), 1'b1);
    q.push_back('{32'd377, TW'(BASE + 1)});
    tick();
    issue = 1'b0;
    drain("self_bcast");
    loop_en = 1'b0;

    // Randomized bursts from an empty bank drain in issue order
    for (int r = 0; r < 15; r++) begin
      k = $urandom_range(1, NRS);
      for (int j = 0; j < k; j++) begin
        tick();
        ra = $urandom; rb = $urandom; rs = 1'($urandom_range(0, 1));
        set_issue(rs ? 6'd1 : 6'd0, ra, 1'b0, rb, 1'b0);
        q.push_back('{ref_alu(rs, ra, rb), TW'(BASE + j)});
        @(negedge clock);
        chk("burst_rs_avail", RS_available, BASE + j);
      end
      tick();
      issue = 1'b0;
      drain("burst");
    end

    // Reset arriving the cycle a result becomes DONE
    tick();
    set_issue(6'd0, 32'd1, 1'b0, 32'd2, 1'b0);
    tick();
    issue = 1'b0;
    repeat (LAT + 1) tick();
    reset = 1'b1;
    @(negedge clock);
    chk("midrst_write", CDB_write, 0);
    chk("midrst_rts", CDB_rts, 0);
    tick();
    reset = 1'b0;
    @(negedge clock);
    chk("midrst_exec", RS_executing, 0);
    chk("midrst_avail", available, 1);
    chk("midrst_rs_avail", RS_available, BASE);
    repeat (LAT + 4) tick();
    @(negedge clock);
    chk("midrst_quiet", CDB_rts, 0);
    chk("sb_empty", q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
